// File: rtl/nanci_node_responder_if.sv
// Nanci request/result bus between an issuing application (master) and a
// node responder (slave). Carries the request channel and the result
// channel, each with its own valid/ready handshake.
interface nanci_node_responder_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 10
);
  localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH + 1;

  logic             req_valid;
  logic             req_ready;
  logic [PKT_W-1:0] req_packet;
  logic             resp_valid;
  logic             resp_ready;
  logic [PKT_W-1:0] resp_packet;

  modport master (
    output req_valid, req_packet, resp_ready,
    input  req_ready, resp_valid, resp_packet
  );

  modport slave (
    input  req_valid, req_packet, resp_ready,
    output req_ready, resp_valid, resp_packet
  );
endinterface

// File: rtl/nanci_node_responder.sv
// Nanci node responder: target-side endpoint that owns one data word.
// Request packets {wr, addr, data} are buffered in a small FIFO and serviced
// in order; writes update the local word, reads return {0, I, local_data}.
// Packets whose address is not this node are dropped and counted.
// Optional build macro NANCI_WRITE_ACK_EN: serviced writes also return an
// acknowledge packet {1, I, new_data} through the result channel.
module nanci_node_responder #(
  parameter int N          = 1024,
  parameter int I          = 0,
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nanci_node_responder_if.slave bus,
  output logic [DATA_WIDTH-1:0] local_data,
  output logic [15:0]           misroute_count
);
  localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // I is always below N; the modulo only keeps the match address in range.
  localparam logic [ADDR_WIDTH-1:0] MY_ADDR    = ADDR_WIDTH'(I % N);
  localparam logic [DATA_WIDTH-1:0] RESET_DATA = DATA_WIDTH'(I);
  localparam logic [PTR_W:0]        FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  logic [PKT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic [0:0]            r_state;
  logic                  r_resp_valid;
  logic [PKT_W-1:0]      r_resp_packet;
  logic [DATA_WIDTH-1:0] r_local_data;
  logic [15:0]           r_misroute_count;

  logic                  w_req_ready;
  logic                  w_push;
  logic                  w_pop;
  logic [PKT_W-1:0]      w_head;
  logic                  w_head_wr;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;

  // req_ready is forced low while reset is held so nothing is taken in.
  assign w_req_ready = rst && (r_count != FULL_COUNT);
  assign w_push      = bus.req_valid && w_req_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_wr   = w_head[PKT_W-1];
  assign w_head_addr = w_head[PKT_W-2:DATA_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  assign bus.req_ready   = w_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_packet = r_resp_packet;
  assign local_data      = r_local_data;
  assign misroute_count  = r_misroute_count;

  // Request storage: write the incoming packet at the tail.
  // NOTE: the data array has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.req_packet;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Service FSM: decode the head packet in IDLE, hold results in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_resp_valid     <= 1'b0;
      r_resp_packet    <= '0;
      r_local_data     <= RESET_DATA;
      r_misroute_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head_addr != MY_ADDR) begin
              if (r_misroute_count != 16'hFFFF)
                r_misroute_count <= r_misroute_count + 16'd1;
            end else if (w_head_wr) begin
              r_local_data <= w_head_data;
`ifdef NANCI_WRITE_ACK_EN
              r_resp_packet <= {1'b1, MY_ADDR, w_head_data};
              r_resp_valid  <= 1'b1;
              r_state       <= S_RESP;
`else
`endif
            end else begin
              r_resp_packet <= {1'b0, MY_ADDR, r_local_data};
              r_resp_valid  <= 1'b1;
              r_state       <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/nanci_node_responder.md
Name: nanci_node_responder

Overview:
- Target-side endpoint of the Nanci request/result packet protocol; the counterpart of an application that issues requests.
- Holds the single data word owned by node I.
- Accepts request packets {wr, addr, data} delivered to this node and buffers them in a small FIFO.
- Services them in order: writes update the local word; reads return a result packet {flag, addr, data} through a valid/ready handshake.

Parameters:
- N, 1024: node count; addresses 0..N-1.
- I, 0: this node's index; only packets with addr == I are serviced.
- DATA_WIDTH, 10: data field width.
- ADDR_WIDTH, 10: address field width.
- FIFO_DEPTH, 4: request buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_valid  input  1  request packet present.
- req_ready  output  1  FIFO can accept a packet this cycle.
- req_packet  input  ADDR_WIDTH+DATA_WIDTH+1  [MSB]=1 write / 0 read; [MSB-1:DATA_WIDTH]=addr; [DATA_WIDTH-1:0]=data (ignored on reads).
- resp_valid  output  1  result packet present.
- resp_ready  input  1  consumer accepts result.
- resp_packet  output  ADDR_WIDTH+DATA_WIDTH+1  [MSB]=0 read result / 1 write ack; addr field = I; data field = local word.
- local_data  output  DATA_WIDTH  current stored word.
- misroute_count  output  16  packets dropped because addr != I.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty, state IDLE, resp_valid=0, resp_packet=0, misroute_count=0.
  - local_data = I truncated to DATA_WIDTH.
  - req_ready is low while rst=0.
  - Reset mid-transaction discards the buffered packets and the pending result.
- Request side:
  - req_ready = !fifo_full.
  - A push occurs on an edge where req_valid && req_ready.
  - When the FIFO is full, req_ready=0 and req_valid is ignored. The sender must hold its packet.
- FSM, two states:
  - IDLE, FIFO non-empty: pop the head at this edge and decode it.
    - addr != I: drop the packet; misroute_count += 1, saturating at 16'hFFFF; stay IDLE.
    - Write: local_data <= data; stay IDLE. This is one packet per cycle throughput.
    - Read: resp_packet <= {1'b0, I, local_data}; resp_valid <= 1; go to RESP.
  - RESP:
    - resp_packet is held stable until resp_valid && resp_ready.
    - On that edge, resp_valid <= 0 and the state returns to IDLE.
    - No FIFO pop occurs in RESP; pushes still occur.
- Latency:
  - Packet pushed at edge t is popped at edge t+1 at the earliest.
  - For a read, resp_valid is high in the cycle after edge t+1.
  - A write is visible on local_data after edge t+1.
- Ordering: strict FIFO order. A read that follows a write returns the written value.
- Simultaneous push and pop in the same edge is legal; the FIFO count is unchanged.
- Address comparison uses the full ADDR_WIDTH field against I.
- Packets with addr >= N are misroutes, because I < N.

Optional Feature:
- Macro: NANCI_WRITE_ACK_EN.
- Defined: a serviced write also produces resp_packet {1'b1, I, new data}, sets resp_valid and enters RESP, like a read.
- Undefined: writes are silent and consume one cycle in IDLE.
- Misroutes never produce a result in either case.

Test Plan (N=1024, I=5, DATA_WIDTH=10, ADDR_WIDTH=10, FIFO_DEPTH=4):
- Reset release, then a read {0, 5, x}, resp_ready=1 -> resp_packet = {0, 5, 10'd5} valid for 1 cycle, 2 cycles after the accept edge.
- Write {1, 5, 10'h3FF}, then read {0, 5, 0} back-to-back -> local_data = 3FF after the first pop; read result data = 3FF. With NANCI_WRITE_ACK_EN, an ack {1, 5, 3FF} precedes it.
- Write to addr 1018 (N-1-I) -> packet dropped, misroute_count = 1, local_data unchanged, no resp_valid.
- Hold resp_ready=0 while pushing 5 reads -> 1 in RESP plus 4 buffered; req_ready=0 with FIFO full. Release resp_ready -> 5 results in order, each held until accepted.
- rst=0 asserted while in RESP with 3 buffered -> resp_valid=0 immediately, FIFO empty, local_data = 5.
- Preload misroute_count to saturation via 65536 misrouted writes -> counter stays at FFFF.
